adpll_tx_seq: RTL and testbench

ADPLL_TX_SEQ -- requirements
Module: adpll_tx_seq

---
 rtl/adpll_tx_seq.sv | 213 +++++++++++++++++++++
 tb/tb_adpll_tx_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/adpll_tx_seq.sv
// ---------------------------------------------------------------------------
// adpll_tx_seq -- transmit-burst sequencer for an all-digital PLL.
//
// Loads the channel frequency word, enables the ADPLL in TX mode, waits for
// channel lock (bounded by LOCK_TIMEOUT), then streams upstream bits onto
// data_mod_o, one bit per SYM_CYCLES clocks. It reports completion with done_o,
// lock problems with lock_err_o, and missing data with underrun_o.
//
// Ports
//   clk_i            system clock (32 MHz), rising edge
//   rst_ni           asynchronous active-low reset
//   start_i          single-cycle burst request (honoured in IDLE / ERR)
//   abort_i          single-cycle cancel (ARM / LOCK_WAIT / SYM / ERR)
//   channel_fcw_i    channel word, MHz x 16384, captured on accepted start
//   tx_bit_i         upstream bit
//   tx_bit_valid_i   upstream bit is valid
//   tx_last_i        upstream bit is the last one of the burst
//   tx_bit_ready_o   bit accepted when valid & ready at a rising edge
//   channel_lock_i   lock indication from the ADPLL controller
//   adpll_en_o       ADPLL enable
//   adpll_mode_o     0=PD 1=TEST 2=RX 3=TX
//   fcw_o            registered channel word
//   data_mod_o       modulation bit
//   busy_o           high outside IDLE and ERR
//   done_o           one-cycle pulse on successful completion
//   lock_err_o       sticky lock timeout / lock loss
//   underrun_o       sticky symbol boundary with no valid bit
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | powered down, waiting for start
// ARM       | one cycle: TX mode selected, ADPLL still disabled
// LOCK_WAIT | ADPLL enabled, waiting for channel_lock with timeout
// SYM       | streaming symbols; lock must stay high
// DONE      | one cycle: done pulse, ADPLL powered down
// ERR       | lock timeout or lock loss; waits for start or abort
// ---------------------------------------------------------------------------
module adpll_tx_seq #(
  parameter int unsigned SYM_CYCLES   = 32,
  parameter int unsigned LOCK_TIMEOUT = 4096
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [25:0] channel_fcw_i,
  input  logic        tx_bit_i,
  input  logic        tx_bit_valid_i,
  input  logic        tx_last_i,
  output logic        tx_bit_ready_o,
  input  logic        channel_lock_i,
  output logic        adpll_en_o,
  output logic [1:0]  adpll_mode_o,
  output logic [25:0] fcw_o,
  output logic        data_mod_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        lock_err_o,
  output logic        underrun_o
);

  localparam int SW = (SYM_CYCLES > 1) ? $clog2(SYM_CYCLES) : 1;
  localparam int LW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [SW-1:0] SYM_LAST  = SW'(SYM_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_TIMEOUT - 1);

  localparam logic [1:0] MODE_PD = 2'd0;
  localparam logic [1:0] MODE_TX = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ARM, ST_LOCK_WAIT, ST_SYM, ST_DONE, ST_ERR
  } state_e;

  state_e      state_q, state_d;
  logic [LW-1:0] wait_cnt_q, wait_cnt_d;
  logic [SW-1:0] sym_cnt_q, sym_cnt_d;
  logic        last_pend_q, last_pend_d;
  logic [25:0] fcw_q, fcw_d;
  logic        data_mod_q, data_mod_d;
  logic        lock_err_q, lock_err_d;
  logic        underrun_q, underrun_d;
  logic        adpll_en_q, busy_q, done_q;
  logic [1:0]  adpll_mode_q;

  // Ready depends only on state and counters, never on inputs.
  assign tx_bit_ready_o = (state_q == ST_SYM) && (sym_cnt_q == SYM_LAST) && !last_pend_q;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    sym_cnt_d   = sym_cnt_q;
    last_pend_d = last_pend_q;
    fcw_d       = fcw_q;
    data_mod_d  = data_mod_q;
    lock_err_d  = lock_err_q;
    underrun_d  = underrun_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d    = ST_ARM;
          fcw_d      = channel_fcw_i;
          lock_err_d = 1'b0;
          underrun_d = 1'b0;
        end
      end
      ST_ARM: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d    = ST_LOCK_WAIT;
          wait_cnt_d = '0;
        end
      end
      ST_LOCK_WAIT: begin
        // Lock beats a simultaneous timeout.
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (channel_lock_i) begin
          state_d     = ST_SYM;
          sym_cnt_d   = SYM_LAST;
          last_pend_d = 1'b0;
        end else if (wait_cnt_q == LOCK_LAST) begin
          state_d    = ST_ERR;
          lock_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_SYM: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (!channel_lock_i) begin
          state_d    = ST_ERR;
          lock_err_d = 1'b1;
        end else if (sym_cnt_q == SYM_LAST) begin
          sym_cnt_d = '0;
          if (last_pend_q) begin
            state_d = ST_DONE;
          end else if (tx_bit_valid_i) begin
            data_mod_d  = tx_bit_i;
            last_pend_d = tx_last_i;
          end else begin
            data_mod_d = 1'b0;
            underrun_d = 1'b1;
          end
        end else begin
          sym_cnt_d = sym_cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (start_i) begin
          state_d    = ST_ARM;
          fcw_d      = channel_fcw_i;
          lock_err_d = 1'b0;
          underrun_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Modulation is only ever driven while symbols are being sent.
    if (state_d != ST_SYM) data_mod_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= '0;
      sym_cnt_q    <= '0;
      last_pend_q  <= 1'b0;
      fcw_q        <= '0;
      data_mod_q   <= 1'b0;
      lock_err_q   <= 1'b0;
      underrun_q   <= 1'b0;
      adpll_en_q   <= 1'b0;
      adpll_mode_q <= MODE_PD;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      sym_cnt_q    <= sym_cnt_d;
      last_pend_q  <= last_pend_d;
      fcw_q        <= fcw_d;
      data_mod_q   <= data_mod_d;
      lock_err_q   <= lock_err_d;
      underrun_q   <= underrun_d;
      // Control outputs are decoded from the next state so they are
      // registered yet line up with the state they describe.
      adpll_en_q   <= (state_d == ST_LOCK_WAIT) || (state_d == ST_SYM);
      adpll_mode_q <= ((state_d == ST_ARM) || (state_d == ST_LOCK_WAIT) ||
                       (state_d == ST_SYM)) ? MODE_TX : MODE_PD;
      busy_q       <= (state_d != ST_IDLE) && (state_d != ST_ERR);
      done_q       <= (state_d == ST_DONE);
    end
  end

  assign adpll_en_o   = adpll_en_q;
  assign adpll_mode_o = adpll_mode_q;
  assign fcw_o        = fcw_q;
  assign data_mod_o   = data_mod_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign lock_err_o   = lock_err_q;
  assign underrun_o   = underrun_q;

endmodule

// File: tb/tb_adpll_tx_seq.sv
`timescale 1ns/1ps
module tb_adpll_tx_seq;

  localparam logic [25:0] FCW0 = 26'd40632320;  // 2480 MHz
  localparam logic [25:0] FCW1 = 26'd39354368;  // 2402 MHz

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, lock, valid, tbit, last;
  logic [25:0] channel_fcw;
  logic        ready, en, data_mod, busy, done, lock_err, underrun;
  logic [1:0]  mode;
  logic [25:0] fcw;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  adpll_tx_seq #(.SYM_CYCLES(32), .LOCK_TIMEOUT(4096)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .channel_fcw_i(channel_fcw), .tx_bit_i(tbit), .tx_bit_valid_i(valid),
    .tx_last_i(last), .tx_bit_ready_o(ready), .channel_lock_i(lock),
    .adpll_en_o(en), .adpll_mode_o(mode), .fcw_o(fcw), .data_mod_o(data_mod),
    .busy_o(busy), .done_o(done), .lock_err_o(lock_err), .underrun_o(underrun)
  );

  always @(negedge clk) if (done) done_cnt++;

  // in: {start, abort, lock, valid, bit, last}
  // ex: {en, mode[1:0], busy, done, lock_err, underrun, data_mod, ready}
  typedef struct {
    int          cyc;
    logic [5:0]  in;
    logic [25:0] fcw_in;
    logic [8:0]  ex;
    logic [25:0] e_fcw;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [5:0] in);
    {start, abort, lock, valid, tbit, last} = in;
  endtask

  task automatic chk_all(input string p, input logic [8:0] ex, input logic [25:0] e_fcw);
    chk({p, "_en"},       32'(en),       32'(ex[8]));
    chk({p, "_mode"},     32'(mode),     32'(ex[7:6]));
    chk({p, "_busy"},     32'(busy),     32'(ex[5]));
    chk({p, "_done"},     32'(done),     32'(ex[4]));
    chk({p, "_lock_err"}, 32'(lock_err), 32'(ex[3]));
    chk({p, "_underrun"}, 32'(underrun), 32'(ex[2]));
    chk({p, "_data_mod"}, 32'(data_mod), 32'(ex[1]));
    chk({p, "_ready"},    32'(ready),    32'(ex[0]));
    chk({p, "_fcw"},      32'(fcw),      32'(e_fcw));
  endtask

  initial begin
    logic [7:0] pat;
    int n;
    pat = 8'b1011_0010;

    // Burst at 2480 MHz: lock 100 cycles after ARM, then 8 bits.
    vq.push_back('{1,  6'b100000, FCW0, 9'b0_11_1_0_0_0_0_0, FCW0});
    vq.push_back('{1,  6'b100000, FCW1, 9'b1_11_1_0_0_0_0_0, FCW0});  // start ignored while busy
    vq.push_back('{99, 6'b000000, FCW1, 9'b1_11_1_0_0_0_0_0, FCW0});
    vq.push_back('{1,  6'b001000, FCW1, 9'b1_11_1_0_0_0_0_1, FCW0});
    for (int i = 0; i < 8; i++) begin
      logic b, l;
      b = pat[7-i];
      l = (i == 7);
      vq.push_back('{32, {3'b001, 1'b1, b, l}, FCW1, {7'b1_11_1_0_0_0, b, ~l}, FCW0});
    end
    vq.push_back('{1,  6'b001000, FCW1, 9'b0_00_1_1_0_0_0_0, FCW0});
    vq.push_back('{1,  6'b000000, FCW1, 9'b0_00_0_0_0_0_0_0, FCW0});
    // Underrun at the second symbol boundary; burst still completes.
    vq.push_back('{1,  6'b100000, FCW1, 9'b0_11_1_0_0_0_0_0, FCW1});
    vq.push_back('{2,  6'b001000, FCW0, 9'b1_11_1_0_0_0_0_1, FCW1});
    vq.push_back('{32, 6'b001110, FCW0, 9'b1_11_1_0_0_0_1_1, FCW1});
    vq.push_back('{32, 6'b001000, FCW0, 9'b1_11_1_0_0_1_0_1, FCW1});
    vq.push_back('{32, 6'b001111, FCW0, 9'b1_11_1_0_0_1_1_0, FCW1});
    vq.push_back('{1,  6'b001000, FCW0, 9'b0_00_1_1_0_1_0_0, FCW1});
    vq.push_back('{1,  6'b000000, FCW0, 9'b0_00_0_0_0_1_0_0, FCW1});
    // Abort in LOCK_WAIT beats a simultaneous lock.
    vq.push_back('{1,  6'b100000, FCW0, 9'b0_11_1_0_0_0_0_0, FCW0});
    vq.push_back('{1,  6'b000000, FCW0, 9'b1_11_1_0_0_0_0_0, FCW0});
    vq.push_back('{1,  6'b011000, FCW0, 9'b0_00_0_0_0_0_0_0, FCW0});
    vq.push_back('{1,  6'b000000, FCW0, 9'b0_00_0_0_0_0_0_0, FCW0});

    rst_n = 1'b0;
    set_in(6'b000000);
    channel_fcw = FCW0;
    #3;
    chk_all("reset", 9'b0, 26'd0);
    #19 rst_n = 1'b1;
    tick();

    for (int i = 0; i < vq.size(); i++) begin
      set_in(vq[i].in);
      channel_fcw = vq[i].fcw_in;
      repeat (vq[i].cyc) tick();
      chk_all($sformatf("row%0d", i), vq[i].ex, vq[i].e_fcw);
    end
    chk("done_pulses_after_table", 32'(done_cnt), 32'd2);

    // Abort together with start and a valid last bit at a symbol boundary.
    channel_fcw = FCW0;
    set_in(6'b100000); tick();
    set_in(6'b001000); tick(); tick();
    chk("abort_pre_ready", 32'(ready), 32'd1);
    set_in(6'b111111); tick();
    chk_all("abort_boundary", 9'b0_00_0_0_0_0_0_0, FCW0);
    set_in(6'b000000); tick();
    chk("abort_after_busy", 32'(busy), 32'd0);
    chk("abort_no_done", 32'(done_cnt), 32'd2);

    // Lock timeout: ERR exactly LOCK_TIMEOUT cycles after entering LOCK_WAIT.
    set_in(6'b100000); tick();
    set_in(6'b000000); tick();
    n = 0;
    while (!lock_err && n < 5000) begin
      tick();
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'd4096);
    chk_all("timeout_err", 9'b0_00_0_0_1_0_0_0, FCW0);
    channel_fcw = FCW1;
    set_in(6'b100000); tick();
    chk_all("err_restart", 9'b0_11_1_0_0_0_0_0, FCW1);
    set_in(6'b010000); tick();
    chk_all("arm_abort", 9'b0_00_0_0_0_0_0_0, FCW1);

    // Lock loss mid-symbol, abort from ERR keeps the flag.
    set_in(6'b100000); tick();
    set_in(6'b001000); tick(); tick();
    set_in(6'b001110); tick();
    set_in(6'b001000); repeat (10) tick();
    chk("mid_sym_data_mod", 32'(data_mod), 32'd1);
    set_in(6'b000000); tick();
    chk_all("lock_loss", 9'b0_00_0_0_1_0_0_0, FCW1);
    set_in(6'b010000); tick();
    chk_all("err_abort", 9'b0_00_0_0_1_0_0_0, FCW1);

    // Next burst, reset pulse mid-symbol.
    channel_fcw = FCW0;
    set_in(6'b100000); tick();
    chk("restart_clears_lock_err", 32'(lock_err), 32'd0);
    set_in(6'b001000); tick(); tick();
    set_in(6'b001110); tick();
    set_in(6'b001000); repeat (5) tick();
    chk("pre_rst_data_mod", 32'(data_mod), 32'd1);
    #2 rst_n = 1'b0;
    #0.5;
    chk_all("async_rst", 9'b0, 26'd0);
    #0.5 rst_n = 1'b1;
    tick();
    chk("post_rst_busy", 32'(busy), 32'd0);
    set_in(6'b100000); tick();
    chk_all("post_rst_start", 9'b0_11_1_0_0_0_0_0, FCW0);
    set_in(6'b010000); tick();
    set_in(6'b000000); tick();
    chk("final_done_count", 32'(done_cnt), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
